// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: access-size codes, FSM states and store-lane helpers.
package mem_access_stage_pkg;

    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    // Unsigned sizes exist only for loads.
    function automatic logic size_legal(input logic [2:0] f3, input logic is_store);
        case (f3)
            F3Byte, F3Half, F3Word: return 1'b1;
            F3ByteU, F3HalfU:       return ~is_store;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return ~off[0];
            2'b10:   return off == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_data_align.sv
// Selects the addressed byte/half lane of a load word and sign- or zero-extends it.
module mem_access_stage_load_data_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3Byte:  data = {{24{shifted[7]}}, shifted[7:0]};
            F3Half:  data = {{16{shifted[15]}}, shifted[15:0]};
            F3ByteU: data = {24'b0, shifted[7:0]};
            F3HalfU: data = {16'b0, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32 MEM stage: branch resolution, req/gnt/rvalid data-bus access FSM with watchdog,
// and the MEM/WB pipeline register.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic                  Ctl_MemtoReg_in,
    input  logic                  Ctl_RegWrite_in,
    input  logic                  Ctl_MemRead_in,
    input  logic                  Ctl_MemWrite_in,
    input  logic                  Ctl_Branch_in,
    input  logic                  Zero_in,
    input  logic [4:0]            Rd_in,
    input  logic [2:0]            funct3_in,
    input  logic [31:0]           ALUresult_in,
    input  logic [31:0]           ReadData2_in,
    input  logic [31:0]           PCimm_in,
    output logic                  PCSrc_out,
    output logic [31:0]           PCtarget_out,
    output logic                  stall_out,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [31:0]           dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [31:0]           dmem_rdata,
    output logic                  Ctl_MemtoReg_out,
    output logic                  Ctl_RegWrite_out,
    output logic [4:0]            Rd_out,
    output logic [31:0]           ReadData_out,
    output logic [31:0]           ALUresult_out,
    output logic                  access_err_out
);

    localparam int unsigned    WdW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

    state_e         state_q;
    logic [WdW-1:0] wd_q;
    logic [2:0]     f3_q;
    logic [1:0]     off_q;
    logic [31:0]    ld_q;
    logic           timeout_q;
    logic [31:0]    ld_data;
    logic           mem_op;
    logic           legal;
    logic           wd_expire;

    assign mem_op    = valid_in & (Ctl_MemRead_in | Ctl_MemWrite_in);
    assign legal     = size_legal(funct3_in, Ctl_MemWrite_in)
                     & addr_aligned(funct3_in, ALUresult_in[1:0]);
    assign wd_expire = (TIMEOUT != 0) && (wd_q == WdLast);

    assign PCSrc_out    = valid_in & Ctl_Branch_in & Zero_in;
    assign PCtarget_out = PCimm_in;
    assign dmem_req     = (state_q == StReq);
    assign stall_out    = (state_q == StReq) || (state_q == StWait)
                       || ((state_q == StIdle) && mem_op && legal);

    mem_access_stage_load_data_align u_align (
        .funct3 (f3_q),
        .offset (off_q),
        .rdata  (dmem_rdata),
        .data   (ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            wd_q             <= '0;
            f3_q             <= '0;
            off_q            <= '0;
            ld_q             <= '0;
            timeout_q        <= 1'b0;
            dmem_we          <= 1'b0;
            dmem_addr        <= '0;
            dmem_be          <= '0;
            dmem_wdata       <= '0;
            Ctl_MemtoReg_out <= 1'b0;
            Ctl_RegWrite_out <= 1'b0;
            Rd_out           <= '0;
            ReadData_out     <= '0;
            ALUresult_out    <= '0;
            access_err_out   <= 1'b0;
        end else begin
            access_err_out <= 1'b0;
            case (state_q)
                StIdle: begin
                    Rd_out        <= Rd_in;
                    ALUresult_out <= ALUresult_in;
                    ReadData_out  <= '0;
                    if (mem_op) begin
                        // Bubble into MEM/WB; the real write-back happens from DONE.
                        Ctl_MemtoReg_out <= 1'b0;
                        Ctl_RegWrite_out <= 1'b0;
                        if (legal) begin
                            state_q    <= StReq;
                            wd_q       <= '0;
                            timeout_q  <= 1'b0;
                            ld_q       <= '0;
                            f3_q       <= funct3_in;
                            off_q      <= ALUresult_in[1:0];
                            dmem_we    <= Ctl_MemWrite_in;
                            dmem_addr  <= {ALUresult_in[ADDR_WIDTH-1:2], 2'b00};
                            dmem_be    <= store_be(funct3_in, ALUresult_in[1:0]);
                            dmem_wdata <= store_wdata(funct3_in, ReadData2_in);
                        end else begin
                            access_err_out <= 1'b1;
                        end
                    end else begin
                        Ctl_MemtoReg_out <= Ctl_MemtoReg_in & valid_in;
                        Ctl_RegWrite_out <= Ctl_RegWrite_in & valid_in;
                    end
                end
                StReq: begin
                    wd_q <= wd_q + WdW'(1);
                    if (dmem_gnt) begin
                        state_q <= dmem_we ? StDone : StWait;
                    end else if (wd_expire) begin
                        state_q        <= StDone;
                        timeout_q      <= 1'b1;
                        access_err_out <= 1'b1;
                    end
                end
                StWait: begin
                    wd_q <= wd_q + WdW'(1);
                    if (dmem_rvalid) begin
                        state_q <= StDone;
                        ld_q    <= ld_data;
                    end else if (wd_expire) begin
                        state_q        <= StDone;
                        timeout_q      <= 1'b1;
                        access_err_out <= 1'b1;
                    end
                end
                StDone: begin
                    state_q          <= StIdle;
                    timeout_q        <= 1'b0;
                    Ctl_MemtoReg_out <= Ctl_MemtoReg_in & valid_in;
                    Ctl_RegWrite_out <= Ctl_RegWrite_in & valid_in & ~timeout_q;
                    Rd_out           <= Rd_in;
                    ALUresult_out    <= ALUresult_in;
                    ReadData_out     <= ld_q;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: vector table, directed bus sequences and a
// randomized mix checked against a byte-addressed memory model.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in;
    logic        Ctl_MemWrite_in, Ctl_Branch_in, Zero_in;
    logic [4:0]  Rd_in;
    logic [2:0]  funct3_in;
    logic [31:0] ALUresult_in, ReadData2_in, PCimm_in;
    logic        PCSrc_out, stall_out, dmem_req, dmem_we;
    logic [31:0] PCtarget_out, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        Ctl_MemtoReg_out, Ctl_RegWrite_out, access_err_out;
    logic [4:0]  Rd_out;
    logic [31:0] ReadData_out, ALUresult_out;

    int n_run  = 0;
    int n_fail = 0;

    logic [7:0] bus_mem [0:255];  // memory as seen through the DUT's bus writes
    logic [7:0] ref_mem [0:255];  // memory as the instruction stream intends it

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .Ctl_MemtoReg_in(Ctl_MemtoReg_in), .Ctl_RegWrite_in(Ctl_RegWrite_in),
        .Ctl_MemRead_in(Ctl_MemRead_in), .Ctl_MemWrite_in(Ctl_MemWrite_in),
        .Ctl_Branch_in(Ctl_Branch_in), .Zero_in(Zero_in), .Rd_in(Rd_in),
        .funct3_in(funct3_in), .ALUresult_in(ALUresult_in), .ReadData2_in(ReadData2_in),
        .PCimm_in(PCimm_in), .PCSrc_out(PCSrc_out), .PCtarget_out(PCtarget_out),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .Ctl_MemtoReg_out(Ctl_MemtoReg_out), .Ctl_RegWrite_out(Ctl_RegWrite_out),
        .Rd_out(Rd_out), .ReadData_out(ReadData_out), .ALUresult_out(ALUresult_out),
        .access_err_out(access_err_out)
    );

    typedef struct {
        logic        v, rw, m2r, br, z;
        logic [4:0]  rd;
        logic [31:0] alu, pcimm;
        logic        exp_pcsrc, exp_rw, exp_m2r;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        valid_in = 0; Ctl_MemtoReg_in = 0; Ctl_RegWrite_in = 0; Ctl_MemRead_in = 0;
        Ctl_MemWrite_in = 0; Ctl_Branch_in = 0; Zero_in = 0; Rd_in = 0; funct3_in = 0;
        ALUresult_in = 0; ReadData2_in = 0; PCimm_in = 0;
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    // Non-memory instruction: called at a negedge with the DUT idle.
    task automatic do_alu(input logic v, rw, m2r, br, z, input logic [4:0] rd,
                          input logic [31:0] alu, pcimm,
                          input logic exp_pcsrc, exp_rw, exp_m2r);
        clear_inputs();
        valid_in = v; Ctl_RegWrite_in = rw; Ctl_MemtoReg_in = m2r; Ctl_Branch_in = br;
        Zero_in = z; Rd_in = rd; ALUresult_in = alu; PCimm_in = pcimm;
        #1;
        chk("alu_pcsrc", PCSrc_out, exp_pcsrc);
        chk("alu_pctarget", PCtarget_out, pcimm);
        chk("alu_stall", stall_out, 0);
        @(negedge clk);
        chk("alu_rd", Rd_out, rd);
        chk("alu_result", ALUresult_out, alu);
        chk("alu_regwrite", Ctl_RegWrite_out, exp_rw);
        chk("alu_memtoreg", Ctl_MemtoReg_out, exp_m2r);
        chk("alu_err", access_err_out, 0);
    endtask

    // Load or store; the bench plays the memory. Called at a negedge with the DUT idle.
    task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [4:0] rd,
                             input int gd, input int rv_dly, output logic [31:0] got);
        int          n, off, k;
        bit          legal, granted;
        logic [31:0] exp_be, exp_wd, exp_ld;
        logic [7:0]  waddr;
        longint      v;
        n      = size_of(f3);
        off    = int'(addr % 4);
        legal  = (n != 0) && !(st && f3[2]) && ((addr % n) == 0);
        exp_be = 32'(((1 << n) - 1) << off) & 32'hF;
        exp_wd = (n == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                 (n == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
        v = 0;
        for (int j = 0; j < n; j++) v = v | (longint'(ref_mem[(addr + j) & 255]) << (8 * j));
        if (n < 4 && !f3[2] && (((v >> (8 * n - 1)) & 1) == 1)) v = v - (longint'(1) << (8 * n));
        exp_ld = 32'(v);
        got    = '0;

        clear_inputs();
        valid_in = 1; Ctl_MemRead_in = !st; Ctl_MemWrite_in = st; Ctl_RegWrite_in = !st;
        Ctl_MemtoReg_in = !st; Rd_in = rd; funct3_in = f3; ALUresult_in = addr;
        ReadData2_in = wd;
        #1;
        chk("issue_stall", stall_out, legal);
        chk("issue_req", dmem_req, 0);
        if (!legal) begin
            @(negedge clk);
            chk("illegal_err", access_err_out, 1);
            chk("illegal_regwrite", Ctl_RegWrite_out, 0);
            chk("illegal_req", dmem_req, 0);
            return;
        end
        if (st) for (int j = 0; j < n; j++) ref_mem[(addr + j) & 255] = 8'(wd >> (8 * j));
        @(negedge clk);
        k = 0; granted = 0; waddr = '0;
        while (!granted) begin
            chk("req_high", dmem_req, 1);
            chk("req_stall", stall_out, 1);
            if (k == 0) begin
                chk("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
                chk("req_we", dmem_we, st);
                if (st) begin
                    chk("req_be", dmem_be, exp_be);
                    chk("req_wdata", dmem_wdata, exp_wd);
                end
                waddr = dmem_addr[7:0];
            end
            if (k == gd) begin
                dmem_gnt = 1; granted = 1;
                if (st) for (int j = 0; j < 4; j++)
                    if (dmem_be[j]) bus_mem[int'(waddr) + j] = dmem_wdata[8*j +: 8];
            end else begin
                dmem_rvalid = 1'($urandom_range(0, 1));  // stray rvalid in REQ is ignored
                dmem_rdata  = $urandom;
            end
            @(negedge clk);
            dmem_gnt = 0; dmem_rvalid = 0;
            k++;
        end
        if (!st) begin
            for (int j = 0; j <= rv_dly; j++) begin
                chk("wait_stall", stall_out, 1);
                chk("wait_req", dmem_req, 0);
                if (j == rv_dly) begin
                    dmem_rvalid = 1;
                    dmem_rdata  = {bus_mem[int'(waddr) + 3], bus_mem[int'(waddr) + 2],
                                   bus_mem[int'(waddr) + 1], bus_mem[int'(waddr)]};
                end
                @(negedge clk);
                dmem_rvalid = 0;
            end
        end
        chk("done_stall", stall_out, 0);
        chk("done_req", dmem_req, 0);
        @(negedge clk);
        chk("wb_rd", Rd_out, rd);
        chk("wb_regwrite", Ctl_RegWrite_out, !st);
        chk("wb_err", access_err_out, 0);
        if (!st) chk("wb_readdata", ReadData_out, exp_ld);
        got = ReadData_out;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs [6];
        logic [31:0] got;
        int          cnt;

        vecs[0] = '{1, 1, 0, 0, 0, 5'd5,  32'h0000_1234, 32'h0,      0, 1, 0};
        vecs[1] = '{1, 0, 0, 1, 1, 5'd0,  32'h0000_0000, 32'h40,     1, 0, 0};
        vecs[2] = '{1, 0, 0, 1, 0, 5'd3,  32'h0000_0001, 32'h80,     0, 0, 0};
        vecs[3] = '{0, 0, 0, 1, 1, 5'd9,  32'h0000_0000, 32'h44,     0, 0, 0};
        vecs[4] = '{0, 1, 1, 0, 0, 5'd7,  32'hCAFE_0000, 32'h0,      0, 0, 0};
        vecs[5] = '{1, 1, 1, 0, 1, 5'd31, 32'hFFFF_FFFF, 32'h1234_5678, 0, 1, 1};

        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end
        reset = 1; clear_inputs();
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_stall", stall_out, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_regwrite", Ctl_RegWrite_out, 0);
        chk("rst_memtoreg", Ctl_MemtoReg_out, 0);
        chk("rst_rd", Rd_out, 0);
        chk("rst_readdata", ReadData_out, 0);
        chk("rst_aluresult", ALUresult_out, 0);
        chk("rst_err", access_err_out, 0);
        reset = 0;
        @(negedge clk);

        foreach (vecs[i])
            do_alu(vecs[i].v, vecs[i].rw, vecs[i].m2r, vecs[i].br, vecs[i].z, vecs[i].rd,
                   vecs[i].alu, vecs[i].pcimm, vecs[i].exp_pcsrc, vecs[i].exp_rw,
                   vecs[i].exp_m2r);

        do_access(1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd0, 0, 0, got);
        do_access(0, 3'b010, 32'h100, 32'h0, 5'd6, 1, 1, got);
        chk("lw_deadbeef", got, 32'hDEAD_BEEF);
        do_access(1, 3'b010, 32'h100, 32'h80FF_FF00, 5'd0, 0, 0, got);
        do_access(0, 3'b000, 32'h103, 32'h0, 5'd9, 2, 0, got);
        chk("lb_sign", got, 32'hFFFF_FF80);
        do_access(0, 3'b100, 32'h103, 32'h0, 5'd10, 2, 0, got);
        chk("lbu_zero", got, 32'h0000_0080);
        do_access(1, 3'b001, 32'h102, 32'h0000_ABCD, 5'd0, 1, 0, got);
        do_access(0, 3'b010, 32'h101, 32'h0, 5'd11, 0, 0, got);
        do_access(0, 3'b101, 32'h102, 32'h0, 5'd12, 0, 2, got);
        chk("lhu_abcd", got, 32'h0000_ABCD);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                logic v, rw, br, z;
                v = 1'($urandom); rw = 1'($urandom); br = 1'($urandom); z = 1'($urandom);
                do_alu(v, rw, 1'b0, br, z, 5'($urandom), $urandom, $urandom,
                       v & br & z, v & rw, 1'b0);
            end else begin
                logic [31:0] a;
                a = 32'($urandom_range(0, 255));
                if (i % 2 == 0) a = a & 32'hFC;
                do_access(1'($urandom), 3'($urandom), a, $urandom, 5'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, 2), got);
            end
        end

        // Load that is never granted: the watchdog must end it.
        clear_inputs();
        valid_in = 1; Ctl_MemRead_in = 1; Ctl_RegWrite_in = 1; Rd_in = 5'd4;
        funct3_in = 3'b010; ALUresult_in = 32'h20;
        @(negedge clk);
        cnt = 0;
        while (dmem_req && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk("to_req_cycles", cnt, 16);
        chk("to_err", access_err_out, 1);
        chk("to_stall", stall_out, 0);
        @(negedge clk);
        clear_inputs();
        chk("to_regwrite", Ctl_RegWrite_out, 0);
        chk("to_err_pulse", access_err_out, 0);

        // Reset while a request is on the bus.
        valid_in = 1; Ctl_MemRead_in = 1; Ctl_RegWrite_in = 1; Rd_in = 5'd8;
        funct3_in = 3'b010; ALUresult_in = 32'h40;
        @(negedge clk);
        chk("rreq_req_before", dmem_req, 1);
        reset = 1; clear_inputs();
        #1;
        chk("rreq_req_drop", dmem_req, 0);
        chk("rreq_stall_drop", stall_out, 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);

        // Reset while waiting for load data; the late rvalid must be ignored.
        valid_in = 1; Ctl_MemRead_in = 1; Ctl_RegWrite_in = 1; Ctl_MemtoReg_in = 1;
        Rd_in = 5'd13; funct3_in = 3'b010; ALUresult_in = 32'h44;
        @(negedge clk);
        dmem_gnt = 1;
        @(negedge clk);
        dmem_gnt = 0;
        chk("rwait_stall_before", stall_out, 1);
        reset = 1; clear_inputs();
        #1;
        chk("rwait_stall_drop", stall_out, 0);
        chk("rwait_req", dmem_req, 0);
        @(negedge clk);
        reset = 0;
        dmem_rvalid = 1; dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        dmem_rvalid = 0;
        chk("rwait_regwrite", Ctl_RegWrite_out, 0);
        chk("rwait_readdata", ReadData_out, 0);
        chk("rwait_rd", Rd_out, 0);
        chk("rwait_aluresult", ALUresult_out, 0);
        chk("rwait_req_after", dmem_req, 0);
        chk("rwait_stall_after", stall_out, 0);
        chk("rwait_err", access_err_out, 0);
        do_alu(1, 1, 0, 0, 0, 5'd21, 32'h5555_AAAA, 32'h0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
